encoder4x2_seq: RTL and testbench
=================================

ENCODER4X2_SEQ -- requirements
Module: encoder4x2_seq

Interface
REQ-001 The block SHALL have parameter PRIO_MODE, default 0, meaning arbitration mode (0 = fixed priority with i0 highest, 1 = round-robin).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, a synchronous active-low reset sampled on the clk rising edge.
REQ-004 The block SHALL have ports i0, i1, i2, i3, each an input of 1 bit, one request line per index 0..3.
REQ-005 The block SHALL have port ready, input, 1 bit, asserted by the consumer to accept the current code.
REQ-006 The block SHALL have port o0, output, 1 bit, the encoded index MSB.
REQ-007 The block SHALL have port o1, output, 1 bit, the encoded index LSB; {o0,o1} = index, so o0/o1 drive i0/i1 of the existing 2x4 decoder and reproduce the one-hot.
REQ-008 The block SHALL have port valid, output, 1 bit, meaning {o0,o1} holds an unconsumed code.
REQ-009 The block SHALL have port busy, output, 1 bit, meaning at least one request is pending.
REQ-010 The block SHALL have port ovf, output, 1 bit, a sticky flag indicating a request was lost.

Function
REQ-011 Each input SHALL be registered into prev[k]; a request event on index k SHALL be i_k=1 with prev[k]=0 at a clk edge.
REQ-012 A request event SHALL set pending[k] at that same edge.
REQ-013 A request event on a bit already pending and not being cleared that edge SHALL leave pending[k]=1 and set ovf.
REQ-014 The output FSM SHALL have two states: EMPTY (valid=0) and HOLD (valid=1).
REQ-015 In EMPTY with pending nonzero, the next edge SHALL select one index, load {o0,o1}, clear its pending bit, and enter HOLD.
REQ-016 In HOLD with ready=1, the current code SHALL be consumed at that edge.
  - pending nonzero (excluding bits set that same edge): load the next selection and stay in HOLD (back-to-back, no bubble).
  - otherwise: enter EMPTY and drop valid.
REQ-017 In HOLD with ready=0, o0, o1 and valid SHALL hold unchanged.
REQ-018 In EMPTY and with ready=0 in HOLD, no pending bit SHALL be cleared.
REQ-019 In EMPTY, ready SHALL be ignored.
REQ-020 Latency: for an isolated event sampled at edge N with output stage EMPTY, valid SHALL be 1 after edge N+1.
REQ-021 When PRIO_MODE=0, selection SHALL be the lowest pending index.
REQ-022 When PRIO_MODE=1, selection SHALL be the first pending index searching upward mod 4 from last_grant+1; last_grant SHALL update on every load.
REQ-023 Set wins over clear: an event on index k at the same edge that selects and clears k SHALL leave pending[k]=1 and SHALL NOT set ovf.
REQ-024 A selection SHALL consider only pending bits registered before the current edge.
REQ-025 busy SHALL equal the OR of the pending register, registered, so it excludes the code currently held in the output stage.
REQ-026 Outputs SHALL be driven only from registers; there SHALL be no combinational path from inputs to outputs.
REQ-027 While valid=0, {o0,o1} SHALL keep the last loaded value.

Reset
REQ-028 With rst_n=0 at an edge, the block SHALL clear pending, prev, valid, o0, o1, busy and ovf to 0, set last_grant=3, and set state=EMPTY.
REQ-029 Reset SHALL override all other activity, including a HOLD-state code, which is discarded; ovf SHALL clear only on reset.
REQ-030 An input held high through reset SHALL produce exactly one event at the first edge with rst_n=1.

Verification
REQ-031 Single request: PRIO_MODE=0, ready=1, pulse i2 for 1 cycle at edge N -> valid=1, o0=1, o1=0 after N+1, for one cycle; busy=0.
REQ-032 Fixed-priority burst: PRIO_MODE=0, i0..i3 rise together, ready=1 -> codes 0,1,2,3 on four consecutive cycles with no bubble, then valid=0.
REQ-033 Round-robin: PRIO_MODE=1, last grant 1, pending {0,3} -> code 3 then code 0.
REQ-034 Backpressure/overflow: ready=0, i1 pulses twice while pending -> code 1 held stable, ovf=1; one code 1 delivered after ready rises.
REQ-035 Set-vs-clear: i1 re-rises on the edge its pending bit is consumed -> pending[1] stays 1, ovf=0, code 1 delivered twice.
REQ-036 Reset mid-HOLD: rst_n=0 for one edge with valid=1 and pending nonzero -> all outputs 0 next cycle; inputs held high -> one event each afterward.

Source files
------------

// File: rtl/encoder4x2_seq.sv
// encoder4x2_seq: edge-detecting 4-to-2 request encoder with a one-entry valid/ready output stage.
// Ports: clk; rst_n (sync, active-low); i0..i3 request lines; ready from consumer;
//        {o0,o1} encoded index (o0 = MSB); valid = code unconsumed; busy = requests pending;
//        ovf = sticky lost-request flag.
module encoder4x2_seq #(
  parameter int PRIO_MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic ready,
  output logic o0,
  output logic o1,
  output logic valid,
  output logic busy,
  output logic ovf
);
  typedef enum logic {EMPTY, HOLD} state_t;
  state_t state;
  logic [3:0] req, prev, pending, ev, clr, pend_nx;
  logic [1:0] sel, idx, last_grant;
  logic load, ovf_set;
  assign req = {i3, i2, i1, i0};
  assign ev = req & ~prev;
  assign load = (pending != 4'd0) && (state == EMPTY || ready);
  // Scan from the highest search offset down so the lowest offset that is pending wins;
  // round-robin rotates the search start to one past the last grant.
  always_comb begin
    sel = 2'd0;
    idx = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      idx = (PRIO_MODE != 0) ? last_grant + 2'(j) + 2'd1 : 2'(j);
      if (pending[idx]) sel = idx;
    end
  end
  assign clr = load ? (4'b0001 << sel) : 4'd0;
  // A fresh event re-sets a bit cleared this edge; it is only lost if the bit stays pending.
  assign pend_nx = (pending & ~clr) | ev;
  assign ovf_set = |(ev & pending & ~clr);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= 4'd0;
      pending <= 4'd0;
      state <= EMPTY;
      valid <= 1'b0;
      o0 <= 1'b0;
      o1 <= 1'b0;
      busy <= 1'b0;
      ovf <= 1'b0;
      last_grant <= 2'd3;
    end else begin
      prev <= req;
      pending <= pend_nx;
      busy <= |pend_nx;
      ovf <= ovf | ovf_set;
      if (load) begin
        {o0, o1} <= sel;
        last_grant <= sel;
        valid <= 1'b1;
        state <= HOLD;
      end else if (state == HOLD && ready) begin
        valid <= 1'b0;
        state <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_encoder4x2_seq.sv
// tb_encoder4x2_seq: directed bench for fixed-priority and round-robin encoder instances.
module tb_encoder4x2_seq;
  logic clk = 1'b0;
  logic rst_n, i0, i1, i2, i3, ready;
  logic f_o0, f_o1, f_valid, f_busy, f_ovf;
  logic r_o0, r_o1, r_valid, r_busy, r_ovf;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  encoder4x2_seq #(.PRIO_MODE(0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .ready(ready),
    .o0(f_o0), .o1(f_o1), .valid(f_valid), .busy(f_busy), .ovf(f_ovf)
  );
  encoder4x2_seq #(.PRIO_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .ready(ready),
    .o0(r_o0), .o1(r_o1), .valid(r_valid), .busy(r_busy), .ovf(r_ovf)
  );
  // Observation word: {valid, o0, o1, busy, ovf}
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [4:0] fix_exp, input logic [4:0] rr_exp);
    compared++;
    assert ({f_valid, f_o0, f_o1, f_busy, f_ovf} === fix_exp)
    else begin
      mismatched++;
      $error("FAIL %s fixed: got %b expected %b", tag, {f_valid, f_o0, f_o1, f_busy, f_ovf}, fix_exp);
    end
    compared++;
    assert ({r_valid, r_o0, r_o1, r_busy, r_ovf} === rr_exp)
    else begin
      mismatched++;
      $error("FAIL %s rr: got %b expected %b", tag, {r_valid, r_o0, r_o1, r_busy, r_ovf}, rr_exp);
    end
  endtask
  task automatic set_in(input logic [3:0] v);
    {i3, i2, i1, i0} = v;
  endtask
  initial begin
    rst_n = 1'b0; ready = 1'b1; set_in(4'b0000);
    step(); step();
    chk("reset", 5'b0_00_0_0, 5'b0_00_0_0);
    rst_n = 1'b1;
    step();
    set_in(4'b0100); step();
    chk("single_event", 5'b0_00_1_0, 5'b0_00_1_0);
    set_in(4'b0000); step();
    chk("single_load", 5'b1_10_0_0, 5'b1_10_0_0);
    step();
    chk("single_drain", 5'b0_10_0_0, 5'b0_10_0_0);
    set_in(4'b1111); step();
    chk("burst_event", 5'b0_10_1_0, 5'b0_10_1_0);
    set_in(4'b0000); step();
    chk("burst_1", 5'b1_00_1_0, 5'b1_11_1_0);
    step();
    chk("burst_2", 5'b1_01_1_0, 5'b1_00_1_0);
    step();
    chk("burst_3", 5'b1_10_1_0, 5'b1_01_1_0);
    step();
    chk("burst_4", 5'b1_11_0_0, 5'b1_10_0_0);
    step();
    chk("burst_end", 5'b0_11_0_0, 5'b0_10_0_0);
    set_in(4'b0010); step();
    chk("rr_pre_event", 5'b0_11_1_0, 5'b0_10_1_0);
    set_in(4'b1001); step();
    chk("rr_grant1", 5'b1_01_1_0, 5'b1_01_1_0);
    set_in(4'b0000); step();
    chk("rr_next", 5'b1_00_1_0, 5'b1_11_1_0);
    step();
    chk("rr_last", 5'b1_11_0_0, 5'b1_00_0_0);
    step();
    chk("rr_end", 5'b0_11_0_0, 5'b0_00_0_0);
    ready = 1'b0; set_in(4'b0010); step();
    chk("bp_event", 5'b0_11_1_0, 5'b0_00_1_0);
    set_in(4'b0000); step();
    chk("bp_load", 5'b1_01_0_0, 5'b1_01_0_0);
    set_in(4'b0010); step();
    chk("bp_pend", 5'b1_01_1_0, 5'b1_01_1_0);
    set_in(4'b0000); step();
    chk("bp_hold", 5'b1_01_1_0, 5'b1_01_1_0);
    set_in(4'b0010); step();
    chk("bp_ovf", 5'b1_01_1_1, 5'b1_01_1_1);
    set_in(4'b0000); step();
    chk("bp_ovf_hold", 5'b1_01_1_1, 5'b1_01_1_1);
    ready = 1'b1; step();
    chk("bp_release", 5'b1_01_0_1, 5'b1_01_0_1);
    step();
    chk("bp_drain", 5'b0_01_0_1, 5'b0_01_0_1);
    rst_n = 1'b0; step();
    chk("sc_reset", 5'b0_00_0_0, 5'b0_00_0_0);
    rst_n = 1'b1; ready = 1'b0; set_in(4'b0010); step();
    chk("sc_event", 5'b0_00_1_0, 5'b0_00_1_0);
    set_in(4'b0000); step();
    chk("sc_load", 5'b1_01_0_0, 5'b1_01_0_0);
    set_in(4'b0010); step();
    chk("sc_pend", 5'b1_01_1_0, 5'b1_01_1_0);
    set_in(4'b0000); step();
    chk("sc_hold", 5'b1_01_1_0, 5'b1_01_1_0);
    set_in(4'b0010); ready = 1'b1; step();
    chk("sc_set_wins", 5'b1_01_1_0, 5'b1_01_1_0);
    set_in(4'b0000); step();
    chk("sc_second", 5'b1_01_0_0, 5'b1_01_0_0);
    step();
    chk("sc_drain", 5'b0_01_0_0, 5'b0_01_0_0);
    ready = 1'b0; set_in(4'b0101); step();
    chk("rh_event", 5'b0_01_1_0, 5'b0_01_1_0);
    step();
    chk("rh_hold", 5'b1_00_1_0, 5'b1_10_1_0);
    rst_n = 1'b0; step();
    chk("rh_reset", 5'b0_00_0_0, 5'b0_00_0_0);
    rst_n = 1'b1; step();
    chk("rh_reevent", 5'b0_00_1_0, 5'b0_00_1_0);
    step();
    chk("rh_load", 5'b1_00_1_0, 5'b1_00_1_0);
    ready = 1'b1; step();
    chk("rh_next", 5'b1_10_0_0, 5'b1_10_0_0);
    step();
    chk("rh_drain", 5'b0_10_0_0, 5'b0_10_0_0);
    step();
    chk("rh_no_repeat", 5'b0_10_0_0, 5'b0_10_0_0);
    set_in(4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
